// File: rtl/piano_pkg.sv
// Shared definitions for the piano key front end: note codes, key count, sustain FSM states
// and the lowest-index key priority function.
package piano_pkg;

  localparam int unsigned NUM_KEYS = 8;

  localparam logic [2:0] NOTE_DO4  = 3'd0;
  localparam logic [2:0] NOTE_RE4  = 3'd1;
  localparam logic [2:0] NOTE_MI4  = 3'd2;
  localparam logic [2:0] NOTE_FA4  = 3'd3;
  localparam logic [2:0] NOTE_SOL4 = 3'd4;
  localparam logic [2:0] NOTE_LA4  = 3'd5;
  localparam logic [2:0] NOTE_SI4  = 3'd6;
  localparam logic [2:0] NOTE_DO5  = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    ON,
    TAIL
  } note_state_e;

  // Index of the lowest pressed key; NOTE_DO4 when nothing is pressed.
  function automatic logic [2:0] lowest_set(input logic [NUM_KEYS-1:0] keys);
    logic [2:0] idx;
    idx = NOTE_DO4;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single key input: two-flop synchroniser followed by a stable-level debouncer that flips its
// output only after DEBOUNCE_CYCLES consecutive differing samples.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_in,
  input  logic rst,
  input  logic key_raw,
  output logic key_db
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    // Any sample matching the accepted level restarts the count, so glitches are dropped.
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = ~db_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_db = db_q;

endmodule

// File: rtl/key_note_encoder.sv
// Piano key front end: debounces eight keys, picks the lowest pressed note and gates the tone
// divider, holding the last note for a programmable sustain tail after release.
module key_note_encoder
  import piano_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SUSTAIN_CYCLES  = 5000000
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys_raw,
  output logic [2:0]          scaler,
  output logic                note_on,
  output logic                note_event,
  output logic [NUM_KEYS-1:0] keys_db
);

  localparam int unsigned SW          = (SUSTAIN_CYCLES > 1) ? $clog2(SUSTAIN_CYCLES) : 1;
  localparam int unsigned TAIL_LAST_I = (SUSTAIN_CYCLES == 0) ? 0 : SUSTAIN_CYCLES - 1;
  localparam logic [SW-1:0] TAIL_LAST = SW'(TAIL_LAST_I);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk_in (clk_in),
      .rst    (rst),
      .key_raw(keys_raw[i]),
      .key_db (keys_db[i])
    );
  end

  note_state_e   state_q, state_d;
  logic [2:0]    scaler_q, scaler_d;
  logic          note_on_q, note_on_d;
  logic          event_q, event_d;
  logic [SW-1:0] tail_q, tail_d;

  logic       any;
  logic [2:0] sel;

  assign any = |keys_db;
  assign sel = lowest_set(keys_db);

  always_comb begin
    state_d  = state_q;
    scaler_d = scaler_q;
    event_d  = 1'b0;
    tail_d   = tail_q;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          state_d  = ON;
          scaler_d = sel;
          event_d  = 1'b1;
        end
      end
      ON: begin
        if (any) begin
          if (sel != scaler_q) begin
            scaler_d = sel;
            event_d  = 1'b1;
          end
        end else if (SUSTAIN_CYCLES == 0) begin
          state_d = IDLE;
        end else begin
          state_d = TAIL;
          tail_d  = '0;
        end
      end
      TAIL: begin
        // A press always wins over expiry; re-pressing the held note is silent.
        if (any) begin
          state_d = ON;
          if (sel != scaler_q) begin
            scaler_d = sel;
            event_d  = 1'b1;
          end
        end else if (tail_q == TAIL_LAST) begin
          state_d = IDLE;
        end else begin
          tail_d = tail_q + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    note_on_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= IDLE;
      scaler_q  <= NOTE_DO4;
      note_on_q <= 1'b0;
      event_q   <= 1'b0;
      tail_q    <= '0;
    end else begin
      state_q   <= state_d;
      scaler_q  <= scaler_d;
      note_on_q <= note_on_d;
      event_q   <= event_d;
      tail_q    <= tail_d;
    end
  end

  assign scaler     = scaler_q;
  assign note_on    = note_on_q;
  assign note_event = event_q;

endmodule

// File: tb/tb_key_note_encoder.sv
// Self-checking bench for key_note_encoder with short debounce (4) and sustain (10) settings.
module tb_key_note_encoder;

  logic       clk_in = 1'b0;
  logic       rst;
  logic [7:0] keys_raw;
  logic [2:0] scaler;
  logic       note_on;
  logic       note_event;
  logic [7:0] keys_db;

  key_note_encoder #(
    .DEBOUNCE_CYCLES(4),
    .SUSTAIN_CYCLES (10)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .keys_raw  (keys_raw),
    .scaler    (scaler),
    .note_on   (note_on),
    .note_event(note_event),
    .keys_db   (keys_db)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [7:0]  raw;
    int unsigned cyc;
    logic [7:0]  db;
    logic [2:0]  scaler;
    logic        on;
    int unsigned ev;
  } vec_t;

  typedef struct {
    logic [7:0]  db;
    logic [2:0]  scaler;
    logic        on;
    int unsigned ev;
  } exp_t;

  vec_t        vecs[9];
  exp_t        sb[$];
  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned ev_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // One clock: outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_in);
    #1;
    if (note_event === 1'b1) ev_cnt++;
  endtask

  initial begin
    logic       lvl[6];
    int         len[6];
    logic       flag;
    exp_t       e;

    //               raw    cyc db     scaler on    ev
    vecs[0] = '{8'h04, 8,  8'h04, 3'd2, 1'b1, 1};  // single press
    vecs[1] = '{8'h30, 8,  8'h30, 3'd4, 1'b1, 1};  // switch to chord
    vecs[2] = '{8'h32, 8,  8'h32, 3'd1, 1'b1, 1};  // lower key joins chord
    vecs[3] = '{8'h30, 8,  8'h30, 3'd4, 1'b1, 1};  // lower key leaves
    vecs[4] = '{8'h00, 16, 8'h00, 3'd4, 1'b1, 0};  // last sustain cycle
    vecs[5] = '{8'h00, 1,  8'h00, 3'd4, 1'b0, 0};  // sustain expired, scaler held
    vecs[6] = '{8'h01, 8,  8'h01, 3'd0, 1'b1, 1};  // press from idle
    vecs[7] = '{8'h81, 8,  8'h81, 3'd0, 1'b1, 0};  // higher key, no change
    vecs[8] = '{8'h80, 8,  8'h80, 3'd7, 1'b1, 1};  // winner released -> switch

    rst      = 1'b1;
    keys_raw = 8'h00;
    repeat (2) step();

    // Reset with all keys pressed.
    keys_raw = 8'hFF;
    step();
    check("rst scaler", 32'(scaler), 0);
    check("rst note_on", 32'(note_on), 0);
    check("rst note_event", 32'(note_event), 0);
    check("rst keys_db", 32'(keys_db), 0);
    rst = 1'b0;
    step();
    check("post-rst scaler", 32'(scaler), 0);
    check("post-rst note_on", 32'(note_on), 0);
    check("post-rst note_event", 32'(note_event), 0);
    check("post-rst keys_db", 32'(keys_db), 0);
    for (int k = 2; k <= 7; k++) begin
      step();
      if (k == 5) check("rst db@5", 32'(keys_db), 32'h00);
      if (k == 6) check("rst db@6", 32'(keys_db), 32'hFF);
      if (k == 7) begin
        check("rst on@7", 32'(note_on), 1);
        check("rst ev@7", 32'(note_event), 1);
      end
    end
    rst      = 1'b1;
    keys_raw = 8'h00;
    step();
    rst = 1'b0;
    step();

    // Table-driven vectors through the scoreboard.
    for (int i = 0; i < 9; i++) begin
      keys_raw = vecs[i].raw;
      ev_cnt   = 0;
      sb.push_back('{vecs[i].db, vecs[i].scaler, vecs[i].on, vecs[i].ev});
      for (int c = 0; c < int'(vecs[i].cyc); c++) step();
      e = sb.pop_front();
      check($sformatf("vec%0d keys_db", i), 32'(keys_db), 32'(e.db));
      check($sformatf("vec%0d scaler", i), 32'(scaler), 32'(e.scaler));
      check($sformatf("vec%0d note_on", i), 32'(note_on), 32'(e.on));
      check($sformatf("vec%0d events", i), ev_cnt, e.ev);
    end

    // Bounce on key 0 from idle.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    lvl    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    len    = '{1, 2, 3, 1, 2, 1};
    flag   = 1'b0;
    ev_cnt = 0;
    for (int p = 0; p < 6; p++) begin
      keys_raw = {7'b0, lvl[p]};
      for (int c = 0; c < len[p]; c++) begin
        step();
        if (keys_db[0] !== 1'b0) flag = 1'b1;
      end
    end
    check("bounce db stable", 32'(flag), 0);
    keys_raw = 8'h01;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 5) check("bounce db@5", 32'(keys_db[0]), 0);
      if (k == 6) check("bounce db@6", 32'(keys_db[0]), 1);
    end
    check("bounce events", ev_cnt, 1);
    check("bounce scaler", 32'(scaler), 0);

    // Release, then re-press the same key mid-tail.
    keys_raw = 8'h00;
    ev_cnt   = 0;
    flag     = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (note_on !== 1'b1) flag = 1'b1;
      if (k == 6) begin
        check("repress released db", 32'(keys_db), 0);
        keys_raw = 8'h01;
      end
    end
    check("repress note_on held", 32'(flag), 0);
    check("repress events", ev_cnt, 0);
    check("repress scaler", 32'(scaler), 0);
    check("repress keys_db", 32'(keys_db), 32'h01);

    // Reset in the middle of the sustain tail.
    keys_raw = 8'h20;
    repeat (8) step();
    check("tail-rst scaler pre", 32'(scaler), 5);
    keys_raw = 8'h00;
    repeat (10) step();
    check("tail-rst in tail", 32'(note_on), 1);
    rst = 1'b1;
    step();
    check("tail-rst note_on", 32'(note_on), 0);
    check("tail-rst scaler", 32'(scaler), 0);
    check("tail-rst note_event", 32'(note_event), 0);
    check("tail-rst keys_db", 32'(keys_db), 0);
    rst = 1'b0;
    step();
    check("tail-rst idle note_on", 32'(note_on), 0);
    check("tail-rst idle scaler", 32'(scaler), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/key_note_encoder.md
Name: key_note_encoder

Overview:
- Upstream stage of the tone divider.
- Takes 8 raw mechanical piano-key inputs, then synchronises, debounces and priority-encodes them.
- Outputs the 3-bit note select (0=Do4 … 7=Do5) that drives the divider's scaler input, plus a gate (note_on) used to mute or enable the audio output.
- A sustain FSM holds the last note for a programmable tail after all keys are released.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a key level change (10 ms at 50 MHz); minimum 1.
- SUSTAIN_CYCLES, 5000000, cycles note_on stays high after the last key is released (100 ms); 0 means no tail.

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- keys_raw  input  8  asynchronous key levels, 1=pressed; bit i = note i.
- scaler  output  3  selected note code, to the divider.
- note_on  output  1  gate: a note is sounding.
- note_event  output  1  one-cycle pulse whenever scaler takes a new value while sounding, or note_on rises.
- keys_db  output  8  debounced key levels, for display.

Behaviour:
- Reset: one clk_in is a single synchronous cycle with rst=1. All outputs return to 0 (scaler=0, note_on=0, note_event=0, keys_db=0). Synchronisers, debounce counters and the sustain counter are cleared, and the FSM goes to IDLE. This applies identically when reset is asserted mid-operation.
- Synchroniser: 2-flop per bit; keys_raw to synchronised value costs 2 cycles.
- Debounce, per bit, with an independent counter of width $clog2(DEBOUNCE_CYCLES+1):
  - If sync == keys_db, the counter is cleared.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 and sync still differs, keys_db toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES resets the count and causes no change.
  - Total latency from a stable edge at keys_raw to keys_db is 2+DEBOUNCE_CYCLES cycles.
- Priority encoder (combinational on keys_db):
  - The lowest set index wins: sel = index of the lowest 1, any = |keys_db.
  - Multiple keys are resolved purely by index, not by press order.
- FSM states:
  - IDLE: note_on=0. If any, go to ON, load scaler<=sel, pulse note_event.
  - ON: note_on=1.
    - If any and sel != scaler: scaler<=sel, pulse note_event.
    - If !any: go to TAIL with the sustain counter at 0, or straight to IDLE if SUSTAIN_CYCLES==0.
  - TAIL: note_on=1, scaler is held, and the counter increments.
    - If any: go to ON, scaler<=sel. note_event pulses only if sel differs from the held scaler.
    - If the counter reaches SUSTAIN_CYCLES-1 with !any: go to IDLE, and note_on falls on the next cycle.
- scaler holds its last value in IDLE and does not return to 0.
- All outputs are registered. note_event, note_on and the scaler update occur together, 1 cycle after keys_db changes.
- Simultaneous events:
  - A release of the winning key while a higher index key is still held is treated as a switch: ON stays, scaler takes the new sel, and note_event pulses.
  - A press on the same cycle as the TAIL expiry gives priority to the press (go to ON).

Decomposition:
- Shared package piano_pkg:
  - note code constants NOTE_DO4 … NOTE_DO5 (3'd0 … 3'd7);
  - NUM_KEYS=8;
  - FSM state enum {IDLE, ON, TAIL}.
- One natural sub-module: key_debounce (single-bit 2-flop sync + counter, parameter DEBOUNCE_CYCLES). It is instantiated 8× via generate.

Test Plan (DEBOUNCE_CYCLES=4, SUSTAIN_CYCLES=10):
- Reset: hold rst for 1 cycle with keys_raw=8'hFF. Required: every output is 0 that cycle and the next; keys_db goes to 8'hFF only 6 cycles after rst drops.
- Single press: keys_raw=8'h04 held stably. Required: keys_db=8'h04 at cycle 6, scaler=2, note_on=1, and note_event pulses for exactly 1 cycle at cycle 7.
- Bounce: toggle bit 0 with pulses 1–3 cycles long, then hold it. Required: keys_db[0] changes only after 4 stable cycles, and exactly one note_event occurs.
- Chord priority: hold 8'h30 (scaler=4), then add bit 1. Required: scaler=1 with a note_event pulse; release bit 1, then scaler=4 with another pulse.
- Sustain: release all keys. Required: note_on stays high for 10 cycles with scaler held at its last value, then returns to 0. Re-pressing the same key at tail cycle 5 keeps note_on high with no note_event.
- Reset mid-tail: assert rst during TAIL. Required: note_on=0 and scaler=0 the next cycle, with the FSM in IDLE.
